// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Assembles a UART byte stream (16-bit LE word count followed by
//               little-endian 32-bit words) into instruction memory writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int IMEM_DATA_WIDTH = 32,
    parameter int NB_LEN          = 16,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    output logic [IMEM_DATA_WIDTH-1:0] o_wdata,
    output logic [IMEM_ADDR_WIDTH-1:0] o_waddr,
    output logic                       o_wen,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [NB_LEN-1:0]          o_word_cnt
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LEN_LO = 3'd1;
    localparam logic [2:0] c_LEN_HI = 3'd2;
    localparam logic [2:0] c_DATA   = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;
    localparam logic [2:0] c_ERROR  = 3'd5;

    localparam logic [NB_LEN:0] c_MAX_WORDS = (NB_LEN+1)'((1 << IMEM_ADDR_WIDTH) / 4);

    logic [2:0]                 r_state;
    logic [NB_LEN-1:0]          r_len;
    logic [1:0]                 r_byte_idx;
    logic [IMEM_DATA_WIDTH-1:0] r_word;
    logic [IMEM_DATA_WIDTH-1:0] r_wdata;
    logic [IMEM_ADDR_WIDTH-1:0] r_waddr;
    logic                       r_wen;
    logic                       r_done;
    logic                       r_error;
    logic [NB_LEN-1:0]          r_word_cnt;

    logic                       w_busy;
    logic                       w_idle_like;
    logic                       w_start_ok;
    logic                       w_tmo_clr;
    logic                       w_tmo_inc;
    logic                       w_tmo_hit;
    logic [NB_LEN-1:0]          w_len_full;
    logic                       w_len_over;
    logic                       w_last;
    logic [IMEM_DATA_WIDTH-1:0] w_full_word;

    assign w_busy      = (r_state == c_LEN_LO) || (r_state == c_LEN_HI) || (r_state == c_DATA);
    assign w_idle_like = (r_state == c_IDLE) || (r_state == c_DONE) || (r_state == c_ERROR);
    assign w_start_ok  = w_idle_like && i_start;
    assign w_tmo_clr   = i_rx_valid || w_start_ok;
    assign w_tmo_inc   = w_busy && !i_rx_valid;
    assign w_len_full  = NB_LEN'({i_rx_data, r_len[7:0]});
    assign w_len_over  = {1'b0, w_len_full} > c_MAX_WORDS;
    assign w_last      = (NB_LEN'(r_word_cnt + 1'b1) == r_len);
    assign w_full_word = {i_rx_data, r_word[IMEM_DATA_WIDTH-9:0]};

    // Idle-gap watchdog; a zero TIMEOUT_CYCLES removes it entirely.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
            logic [c_TMO_W-1:0] r_tmo;

            always_ff @(posedge clk or posedge i_rst) begin
                if (i_rst) begin
                    r_tmo <= '0;
                end else if (w_tmo_clr) begin
                    r_tmo <= '0;
                end else if (w_tmo_inc) begin
                    r_tmo <= r_tmo + c_TMO_W'(1);
                end
            end

            assign w_tmo_hit = w_tmo_inc && (r_tmo == c_TMO_LAST);
        end else begin : g_no_tmo
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= c_IDLE;
            r_len      <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_waddr    <= '0;
            r_wen      <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE, c_ERROR: begin
                    if (i_start) begin
                        r_state    <= c_LEN_LO;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_word_cnt <= '0;
                        r_waddr    <= '0;
                        r_byte_idx <= '0;
                    end
                end

                c_LEN_LO: begin
                    if (w_tmo_hit) begin
                        r_state <= c_ERROR;
                        r_error <= 1'b1;
                    end else if (i_rx_valid) begin
                        r_len   <= NB_LEN'(i_rx_data);
                        r_state <= c_LEN_HI;
                    end
                end

                c_LEN_HI: begin
                    if (w_tmo_hit) begin
                        r_state <= c_ERROR;
                        r_error <= 1'b1;
                    end else if (i_rx_valid) begin
                        r_len <= w_len_full;
                        if (w_len_full == '0) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end else if (w_len_over) begin
                            r_state <= c_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state    <= c_DATA;
                            r_waddr    <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                end

                c_DATA: begin
                    // Bookkeeping for the word written during the previous cycle.
                    if (r_wen) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_waddr <= r_waddr + IMEM_ADDR_WIDTH'(4);
                        end
                    end
                    if (w_tmo_hit && !(r_wen && w_last)) begin
                        r_state <= c_ERROR;
                        r_error <= 1'b1;
                    end
                    if (i_rx_valid && !(r_wen && w_last)) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= i_rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_wdata <= w_full_word;
                            r_wen   <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign o_wdata    = r_wdata;
    assign o_waddr    = r_waddr;
    assign o_wen      = r_wen;
    assign o_busy     = w_busy;
    assign o_done     = r_done;
    assign o_error    = r_error;
    assign o_word_cnt = r_word_cnt;

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream from the UART receiver and assembles it into 32-bit little-endian instruction words.
- Drives the instruction memory write port: data, address and write enable.
- Holds `o_busy` high while a load is in progress, so top-level logic can keep the CPU core stalled or in reset until the program image is fully written.

Parameters:
- IMEM_ADDR_WIDTH, 10: width of the instruction memory byte address. Matches the PC truncation on the read side. MAX_WORDS = 2^IMEM_ADDR_WIDTH / 4 (256 at default).
- IMEM_DATA_WIDTH, 32: instruction word width. Fixed at 32 (4 bytes per word).
- NB_LEN, 16: width of the word-count header field and of `o_word_cnt`.
- TIMEOUT_CYCLES, 1000000: maximum idle clocks between bytes while busy. 0 disables the timeout.

Ports:
- clk, input, 1: system clock. All logic on the rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_start, input, 1: one-cycle pulse that arms a new load.
- i_rx_data, input, 8: received byte from the UART receiver.
- i_rx_valid, input, 1: one-cycle strobe, `i_rx_data` valid.
- o_wdata, output, IMEM_DATA_WIDTH: word to the instruction memory `i_din`.
- o_waddr, output, IMEM_ADDR_WIDTH: byte address to the instruction memory `i_addr`, always a multiple of 4.
- o_wen, output, 1: one-cycle write strobe to the instruction memory `i_wen`.
- o_busy, output, 1: load in progress.
- o_done, output, 1: last load completed successfully.
- o_error, output, 1: last load aborted (length overflow or timeout).
- o_word_cnt, output, NB_LEN: words written in the current or last load.

Behaviour:
- **Reset:** `i_rst` high asynchronously forces state IDLE and all outputs, byte index, length and timeout counter to 0. A partial word is discarded.
- **States:** IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR. `o_busy` = 1 in LEN_LO, LEN_HI and DATA only.
- **IDLE / DONE / ERROR:**
  - `i_rx_valid` bytes are ignored.
  - `i_start` moves to LEN_LO and clears `o_done`, `o_error`, `o_word_cnt`, the address and the byte index.
  - If `i_start` and `i_rx_valid` arrive in the same cycle, start wins and the byte is dropped.
- **Busy states:** `i_start` is ignored.
- **LEN_LO:** on `i_rx_valid`, latch bits [7:0] of N and go to LEN_HI.
- **LEN_HI:** on `i_rx_valid`, latch bits [15:8] of N, then:
  - N == 0: go to DONE.
  - N > MAX_WORDS: go to ERROR.
  - Otherwise: go to DATA with address 0 and byte index 0.
- **DATA:**
  - Each valid byte is placed at byte lane `byte_idx`: first byte to [7:0], fourth byte to [31:24]. `byte_idx` then increments modulo 4.
  - **Write timing:** when the 4th byte is sampled at edge k, `o_wen` is high for exactly one cycle after edge k. `o_wdata` carries the full word and `o_waddr` the current address during that cycle.
  - At edge k+1 the address advances by 4 and `o_word_cnt` increments.
  - After word N is written, go to DONE: `o_done` = 1 and `o_busy` = 0 in the same cycle as the final `o_wen` deassertion.
- **Back-to-back input:** `i_rx_valid` on every consecutive cycle must be accepted with no byte loss. The first byte of the next word may be sampled during the `o_wen` cycle.
- **Timeout:**
  - A counter clears on every `i_rx_valid` and on entry to LEN_LO, and increments each busy cycle without valid.
  - When it reaches TIMEOUT_CYCLES (nonzero), go to ERROR. A pending partial word is not written.
- **Sticky flags:** `o_done` and `o_error` hold until the next `i_start` or reset. They are never both 1.
- **Address range:** no wrap. Address never exceeds (MAX_WORDS-1)*4 because N is range-checked.
- **Output stability:** `o_wdata` and `o_waddr` hold their last values when `o_wen` = 0.

Test Plan:
1. Reset, `i_start`, bytes 02 00 13 00 00 00 B3 80 20 00 → writes 0x00000013 @0x000 and 0x002080B3 @0x004, each with a 1-cycle `o_wen` after the 4th byte; then `o_done` = 1, `o_busy` = 0, `o_word_cnt` = 2.
2. Bytes sent before `i_start`, then `i_start` with 00 00 → no `o_wen`; `o_done` = 1 one cycle after the 2nd header byte.
3. Default width: header 01 01 (N=257) → `o_error` = 1, no writes. Then `i_start`, header 00 01 plus 1024 bytes → 256 writes, last at 0x3FC, `o_done` = 1.
4. TIMEOUT_CYCLES = 16: `i_start`, 01 00 AA BB, then 16 idle clocks → `o_error` = 1, `o_busy` = 0, no `o_wen`.
5. `i_rx_valid` held high for 14 consecutive cycles (header 03 00 plus 12 bytes) → three `o_wen` pulses at 0x000, 0x004, 0x008 with correct words; no byte lost.
6. Assert `i_rst` asynchronously after 2 data bytes → all outputs 0 before the next edge. Then `i_start` and 01 00 DE AD BE EF → 0xEFBEADDE @0x000.
